// File: rtl/dram_arb_pkg.sv
// Shared types and default widths for the DRAM arbiter.
package dram_arb_pkg;

   // Default widths match the 16-bit single-port main-memory DRAM.
   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2,
      ACK     = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// The search begins at the core after the last winner, so the last
// winner always has the lowest priority.
module rr_arbiter
   import dram_arb_pkg::*;
#(
   parameter int NUM_CORES = 4,
   parameter int IDX_W     = $clog2(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] i_req,
   input  logic [IDX_W-1:0]     i_last,
   output logic [IDX_W-1:0]     o_winner,
   output logic                 o_any_req
);

   logic [NUM_CORES-1:0] w_rot;
   logic [IDX_W-1:0]     w_idx;
   logic [IDX_W-1:0]     w_enc;

   // Rotate requests so bit 0 is the core after the last winner,
   // priority-encode the lowest set bit, then undo the rotation.
   always_comb begin
      w_rot     = '0;
      w_idx     = '0;
      w_enc     = '0;
      o_winner  = '0;
      o_any_req = |i_req;
      for (int i = 0; i < NUM_CORES; i++) begin
         w_idx    = IDX_W'((int'(i_last) + 1 + i) % NUM_CORES);
         w_rot[i] = i_req[w_idx];
      end
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_enc = IDX_W'(i);
         end
      end
      o_winner = IDX_W'((int'(i_last) + 1 + int'(w_enc)) % NUM_CORES);
   end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter serializing single-word core requests onto a
// single-port DRAM with a one-cycle registered read output.
module dram_arbiter
   import dram_arb_pkg::*;
#(
   parameter  int NUM_CORES = 4,
   parameter  int ADDR_W    = ADDR_W_DEF,
   parameter  int DATA_W    = DATA_W_DEF,
   localparam int IDX_W     = $clog2(NUM_CORES)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CORES-1:0]        core_req,
   input  logic [NUM_CORES-1:0]        core_we,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
   output logic [NUM_CORES-1:0]        core_ack,
   output logic [DATA_W-1:0]           core_rdata,
   output logic [IDX_W-1:0]            grant_id,
   output logic                        busy,
   output logic                        mem_we,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [IDX_W-1:0]   r_last;
   logic [IDX_W-1:0]   r_grant;
   logic               r_mem_we;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [DATA_W-1:0]  r_mem_wdata;
   logic [DATA_W-1:0]  r_rdata;

   logic [IDX_W-1:0]   w_winner;
   logic               w_any_req;
   logic [ADDR_W-1:0]  w_addr_arr  [NUM_CORES];
   logic [DATA_W-1:0]  w_wdata_arr [NUM_CORES];

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
      assign w_addr_arr[g]  = core_addr[g*ADDR_W +: ADDR_W];
      assign w_wdata_arr[g] = core_wdata[g*DATA_W +: DATA_W];
   end

   rr_arbiter #(
      .NUM_CORES (NUM_CORES),
      .IDX_W     (IDX_W)
   ) u_rr (
      .i_req     (core_req),
      .i_last    (r_last),
      .o_winner  (w_winner),
      .o_any_req (w_any_req)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and per-state outputs; a write skips CAPTURE since the
   // DRAM has already committed by the end of ISSUE.
   always_comb begin
      w_state_nxt = r_state;
      core_ack    = '0;
      busy        = (r_state != IDLE);
      unique case (r_state)
         IDLE:    if (w_any_req) w_state_nxt = ISSUE;
         ISSUE:   w_state_nxt = r_mem_we ? ACK : CAPTURE;
         CAPTURE: w_state_nxt = ACK;
         ACK: begin
            core_ack[r_grant] = 1'b1;
            w_state_nxt       = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Grant latch, DRAM port registers and read-data capture. mem_addr and
   // mem_wdata hold after ISSUE; only mem_we is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last      <= IDX_W'(NUM_CORES - 1);
         r_grant     <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rdata     <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_grant     <= w_winner;
                  r_last      <= w_winner;
                  r_mem_we    <= core_we[w_winner];
                  r_mem_addr  <= w_addr_arr[w_winner];
                  r_mem_wdata <= w_wdata_arr[w_winner];
               end
            end
            ISSUE:   r_mem_we <= 1'b0;
            CAPTURE: r_rdata  <= mem_rdata;
            default: ;
         endcase
      end
   end

   assign grant_id   = r_grant;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign core_rdata = r_rdata;

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Round-robin arbiter that shares the single-port 16-bit main-memory DRAM among the processor cores. Each core issues single-word read or write requests over a req/ack handshake. The arbiter serializes them onto the DRAM's write_en/addr/data_in port and returns read data captured from the DRAM's one-cycle registered output. It sits between the per-core memory interfaces and the DRAM instance at the top level.

## Interface
- NUM_CORES, 4: number of requesting cores (≥2).
- ADDR_W, 16: address width, matches DRAM addr.
- DATA_W, 16: data width, matches DRAM data.
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- core_req  in  NUM_CORES  per-core request; held high until ack.
- core_we  in  NUM_CORES  per-core 1 = write, 0 = read; stable while req high.
- core_addr  in  NUM_CORES*ADDR_W  per-core address, core i at bits [i*ADDR_W +: ADDR_W].
- core_wdata  in  NUM_CORES*DATA_W  per-core write data, same packing.
- core_ack  out  NUM_CORES  one-cycle completion pulse, one-hot or zero.
- core_rdata  out  DATA_W  read data; valid in the ack cycle of a read.
- grant_id  out  $clog2(NUM_CORES)  index of the core currently being served.
- busy  out  1  high whenever state ≠ IDLE.
- mem_we  out  1  to DRAM write_en.
- mem_addr  out  ADDR_W  to DRAM addr.
- mem_wdata  out  DATA_W  to DRAM data_in.
- mem_rdata  in  DATA_W  from DRAM data_out.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, ACK.
- IDLE: if any core_req is set, select the winner by round robin. The search starts at (last + 1) mod NUM_CORES. At the edge, latch grant_id, last <= winner, mem_addr, mem_wdata, and mem_we <= core_we[winner]. Then go to ISSUE. If no request is set, stay in IDLE.
- ISSUE: mem_* outputs are stable and the DRAM executes at this edge. mem_we <= 0 at this edge. A write goes to ACK; a read goes to CAPTURE.
- CAPTURE: mem_rdata now holds the DRAM word. core_rdata <= mem_rdata, then go to ACK.
- ACK: core_ack[grant_id] = 1 for exactly this cycle, then return to IDLE unconditionally.
- Requester rule: deassert req, or present the next request, at the edge ending its ack cycle. A req still high in the following IDLE cycle is a new request.
- Fairness: the winner becomes the lowest priority. With all cores requesting continuously, grants rotate 0,1,…,N-1,0.
- A write acks with core_rdata unchanged (it holds the last read value).
- mem_we is high only during ISSUE of a write. In all other states the DRAM performs don't-care reads.

## Timing
- Reset values:
  - state = IDLE, last = NUM_CORES-1 (core 0 wins first)
  - grant_id = 0, busy = 0
  - core_ack = 0, core_rdata = 0
  - mem_we = 0, mem_addr = 0, mem_wdata = 0
- Latency, measured from the edge that samples req in IDLE (cycle 0):
  - Write: DRAM commits at the end of cycle 1; ack in cycle 2.
  - Read: DRAM read at the end of cycle 1; capture in cycle 2; ack with data in cycle 3.
- Throughput: one write per 3 cycles, one read per 4 cycles (IDLE re-arbitrates after every ACK).
- Simultaneous requests: exactly one grant per IDLE pass; the losers stay pending with no ack.
- Requests arriving while busy are not sampled until the next IDLE.
- rst mid-operation: next state is IDLE with all outputs at reset values and no ack issued.
  - A write whose ISSUE cycle coincides with rst still commits, because the DRAM samples at that edge.
  - A read in CAPTURE is discarded.
- Address and data pass through unmodified. No wrap logic is needed; address 16'hFFFF is a valid word.

## Structure
- Package dram_arb_pkg: state enum (IDLE, ISSUE, CAPTURE, ACK), ADDR_W/DATA_W defaults.
- Sub-module rr_arbiter (combinational):
  - Inputs: req vector and last pointer.
  - Outputs: winner index and any_req.
  - Implementation: rotate, priority-encode, add offset mod N.
- Top: FSM, latches, and output registers.

## Test plan
- After reset, core0 reads addr 5 (DRAM preloaded with 75) -> mem_we stays 0, core_ack[0] in cycle 3, core_rdata = 75.
- Core1 writes 16'd1234 to addr 10 -> mem_we high for one cycle with mem_addr = 10 and core_ack[1] in cycle 2. A following core1 read of addr 10 returns 1234.
- All four cores request simultaneously after reset, each holding req until ack -> acks in order 0,1,2,3, with no two acks in the same cycle.
- Cores 0 and 2 request continuously -> grants alternate 0,2,0,2; cores 1 and 3 never ack.
- Core3 reads addr 25 (65450) with rst asserted during CAPTURE -> no ack, next cycle IDLE with core_rdata = 0. A re-issued read returns 65450.
- Write 16'hFFFF to addr 16'hFFFF, then read it back -> 16'hFFFF. busy is high from cycle 1 through the ack cycle of each access.
